// File: rtl/ant_frame_scheduler.sv
// Per-frame ant sequencer: runs update then draw for each ant id and muxes the owning engine
// onto the shared datapath. Optional watchdog: define ANT_SCHED_WATCHDOG_EN.
module ant_frame_scheduler #(
  parameter int unsigned NUM_ANTS     = 8,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_tick,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    timeout_err,
  output logic [ID_WIDTH-1:0]     ant_id,
  output logic                    upd_start,
  input  logic                    upd_finished,
  output logic                    drw_start,
  input  logic                    drw_finished,
  input  logic                    upd_start_dp,
  input  logic [INSTR_WIDTH-1:0]  upd_instruction_dp,
  output logic                    upd_finished_dp,
  output logic [RESULT_WIDTH-1:0] upd_result_dp,
  input  logic                    drw_start_dp,
  input  logic [INSTR_WIDTH-1:0]  drw_instruction_dp,
  output logic                    drw_finished_dp,
  output logic [RESULT_WIDTH-1:0] drw_result_dp,
  output logic                    start_dp,
  output logic [INSTR_WIDTH-1:0]  instruction_dp,
  input  logic                    finished_dp,
  input  logic [RESULT_WIDTH-1:0] result_dp
);

  typedef enum logic [2:0] {
    StIdle,
    StUpdGo,
    StUpdWait,
    StDrwGo,
    StDrwWait,
    StNext,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnUpd,
    OwnDrw
  } owner_e;

  localparam logic [ID_WIDTH-1:0] LastId = ID_WIDTH'(NUM_ANTS - 1);

  state_e state_q;
  owner_e owner_q;
  logic   busy_seen_q;
  logic   wd_expired;

`ifdef ANT_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           in_wait;

  assign in_wait    = (state_q == StUpdWait) || (state_q == StDrwWait);
  assign wd_expired = in_wait && (wd_cnt_q == WdMax);

  // Counter restarts in each GO state so every wait gets a full budget.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state_q == StUpdGo) || (state_q == StDrwGo)) begin
        wd_cnt_q <= '0;
      end else if (in_wait && !wd_expired) begin
        wd_cnt_q <= wd_cnt_q + WdW'(1);
      end
      if (wd_expired) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      busy_seen_q <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      ant_id      <= '0;
      upd_start   <= 1'b0;
      drw_start   <= 1'b0;
    end else begin
      upd_start  <= 1'b0;
      drw_start  <= 1'b0;
      frame_done <= 1'b0;
      // busy stays high through DONE, so this also covers a tick in the DONE cycle.
      if (frame_tick && busy) begin
        overrun <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (frame_tick) begin
            ant_id    <= '0;
            busy      <= 1'b1;
            upd_start <= 1'b1;
            owner_q   <= OwnUpd;
            state_q   <= StUpdGo;
          end
        end
        StUpdGo: begin
          busy_seen_q <= 1'b0;
          state_q     <= StUpdWait;
        end
        StUpdWait: begin
          if (!upd_finished) begin
            busy_seen_q <= 1'b1;
          end
          // A finished level that never dropped is stale from a previous run.
          if ((upd_finished && busy_seen_q) || wd_expired) begin
            drw_start <= 1'b1;
            owner_q   <= OwnDrw;
            state_q   <= StDrwGo;
          end
        end
        StDrwGo: begin
          busy_seen_q <= 1'b0;
          state_q     <= StDrwWait;
        end
        StDrwWait: begin
          if (!drw_finished) begin
            busy_seen_q <= 1'b1;
          end
          if ((drw_finished && busy_seen_q) || wd_expired) begin
            owner_q <= OwnNone;
            state_q <= StNext;
          end
        end
        StNext: begin
          if (ant_id == LastId) begin
            frame_done <= 1'b1;
            state_q    <= StDone;
          end else begin
            ant_id    <= ant_id + ID_WIDTH'(1);
            upd_start <= 1'b1;
            owner_q   <= OwnUpd;
            state_q   <= StUpdGo;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          owner_q <= OwnNone;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Non-owners see a quiet response; no owner means an idle shared request.
  always_comb begin
    start_dp        = 1'b0;
    instruction_dp  = '0;
    upd_finished_dp = 1'b0;
    upd_result_dp   = '0;
    drw_finished_dp = 1'b0;
    drw_result_dp   = '0;
    case (owner_q)
      OwnUpd: begin
        start_dp        = upd_start_dp;
        instruction_dp  = upd_instruction_dp;
        upd_finished_dp = finished_dp;
        upd_result_dp   = result_dp;
      end
      OwnDrw: begin
        start_dp        = drw_start_dp;
        instruction_dp  = drw_instruction_dp;
        drw_finished_dp = finished_dp;
        drw_result_dp   = result_dp;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ant_frame_scheduler.sv
// Directed bench for ant_frame_scheduler: 3 ants, engines finishing 5 cycles after start.
module tb_ant_frame_scheduler;

  localparam int unsigned NumAnts    = 3;
  localparam int unsigned IdW        = 8;
  localparam int unsigned InstrW     = 32;
  localparam int unsigned ResW       = 16;
  localparam int unsigned Timeout    = 16;
  localparam int unsigned EngLat     = 5;
  // Per ant: 1 + (5+1) + 1 + (5+1) + 1 = 15; three ants plus DONE = 46.
  localparam int          PassCycles = 46;

  logic              clock = 1'b0;
  logic              reset;
  logic              frame_tick;
  logic              busy;
  logic              frame_done;
  logic              overrun;
  logic              timeout_err;
  logic [IdW-1:0]    ant_id;
  logic              upd_start;
  logic              upd_finished;
  logic              drw_start;
  logic              drw_finished;
  logic              upd_start_dp;
  logic [InstrW-1:0] upd_instruction_dp;
  logic              upd_finished_dp;
  logic [ResW-1:0]   upd_result_dp;
  logic              drw_start_dp;
  logic [InstrW-1:0] drw_instruction_dp;
  logic              drw_finished_dp;
  logic [ResW-1:0]   drw_result_dp;
  logic              start_dp;
  logic [InstrW-1:0] instruction_dp;
  logic              finished_dp;
  logic [ResW-1:0]   result_dp;

  ant_frame_scheduler #(
    .NUM_ANTS    (NumAnts),
    .ID_WIDTH    (IdW),
    .INSTR_WIDTH (InstrW),
    .RESULT_WIDTH(ResW),
    .TIMEOUT     (Timeout)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .frame_tick        (frame_tick),
    .busy              (busy),
    .frame_done        (frame_done),
    .overrun           (overrun),
    .timeout_err       (timeout_err),
    .ant_id            (ant_id),
    .upd_start         (upd_start),
    .upd_finished      (upd_finished),
    .drw_start         (drw_start),
    .drw_finished      (drw_finished),
    .upd_start_dp      (upd_start_dp),
    .upd_instruction_dp(upd_instruction_dp),
    .upd_finished_dp   (upd_finished_dp),
    .upd_result_dp     (upd_result_dp),
    .drw_start_dp      (drw_start_dp),
    .drw_instruction_dp(drw_instruction_dp),
    .drw_finished_dp   (drw_finished_dp),
    .drw_result_dp     (drw_result_dp),
    .start_dp          (start_dp),
    .instruction_dp    (instruction_dp),
    .finished_dp       (finished_dp),
    .result_dp         (result_dp)
  );

  always #5 clock = ~clock;

  // Engine models: finished drops on start and rises EngLat cycles later.
  logic       upd_stuck = 1'b0;
  logic       upd_hang  = 1'b0;
  logic [3:0] upd_cnt;
  logic [3:0] drw_cnt;

  always @(posedge clock) begin
    if (reset) begin
      upd_finished <= 1'b1;
      upd_cnt      <= '0;
    end else if (upd_start && !upd_stuck) begin
      upd_finished <= 1'b0;
      upd_cnt      <= 4'(EngLat);
    end else if (upd_cnt != 4'd0) begin
      upd_cnt <= upd_cnt - 4'd1;
      if (upd_cnt == 4'd1 && !upd_hang) upd_finished <= 1'b1;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      drw_finished <= 1'b1;
      drw_cnt      <= '0;
    end else if (drw_start) begin
      drw_finished <= 1'b0;
      drw_cnt      <= 4'(EngLat);
    end else if (drw_cnt != 4'd0) begin
      drw_cnt <= drw_cnt - 4'd1;
      if (drw_cnt == 4'd1) drw_finished <= 1'b1;
    end
  end

  // Pulse monitor; the main flow snapshots these before each scenario.
  int n_upd_start = 0;
  int n_drw_start = 0;
  int n_done      = 0;
  int id_log[$];

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (upd_start === 1'b1) n_upd_start <= n_upd_start + 1;
      if (drw_start === 1'b1) n_drw_start <= n_drw_start + 1;
      if (frame_done === 1'b1) n_done <= n_done + 1;
      if (upd_start === 1'b1 || drw_start === 1'b1) id_log.push_back(int'(ant_id));
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic clear_dp();
    upd_start_dp       = 1'b0;
    upd_instruction_dp = '0;
    drw_start_dp       = 1'b0;
    drw_instruction_dp = '0;
    finished_dp        = 1'b0;
    result_dp          = '0;
  endtask

  int base_u;
  int base_d;
  int base_f;
  int base_l;
  int exp_ids[6] = '{0, 0, 1, 1, 2, 2};

  initial begin
    #1000000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    clear_dp();
    // Drive the requests hard while in reset: owner NONE must keep the shared port quiet.
    upd_start_dp       = 1'b1;
    upd_instruction_dp = 32'hFFFF_FFFF;
    finished_dp        = 1'b1;
    result_dp          = 16'hFFFF;
    repeat (3) step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst_ant_id", 32'(ant_id), 32'd0);
    check_eq("rst_upd_start", 32'(upd_start), 32'd0);
    check_eq("rst_drw_start", 32'(drw_start), 32'd0);
    check_eq("rst_start_dp", 32'(start_dp), 32'd0);
    check_eq("rst_instruction_dp", instruction_dp, 32'd0);
    check_eq("rst_upd_finished_dp", 32'(upd_finished_dp), 32'd0);
    check_eq("rst_upd_result_dp", 32'(upd_result_dp), 32'd0);
    reset = 1'b0;
    clear_dp();
    step();

    // Plain frame.
    base_u = n_upd_start; base_d = n_drw_start; base_f = n_done; base_l = id_log.size();
    pulse_tick();
    cyc = 1;
    check_eq("f1_busy_rise", 32'(busy), 32'd1);
    check_eq("f1_upd_start_first", 32'(upd_start), 32'd1);
    check_eq("f1_first_id", 32'(ant_id), 32'd0);
    while (frame_done !== 1'b1 && cyc < 400) step();
    check_eq("f1_pass_len", 32'(cyc), 32'(PassCycles));
    step();
    check_eq("f1_busy_fall", 32'(busy), 32'd0);
    check_eq("f1_done_one_cycle", 32'(frame_done), 32'd0);
    step();
    check_eq("f1_upd_pulses", 32'(n_upd_start - base_u), 32'd3);
    check_eq("f1_drw_pulses", 32'(n_drw_start - base_d), 32'd3);
    check_eq("f1_done_pulses", 32'(n_done - base_f), 32'd1);
    check_eq("f1_overrun", 32'(overrun), 32'd0);
    check_eq("f1_id_log_len", 32'(id_log.size() - base_l), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("f1_id_seq%0d", i), 32'(id_log[base_l + i]), 32'(exp_ids[i]));
    end

    // Datapath arbitration plus an overrun tick mid-pass.
    base_u = n_upd_start; base_f = n_done;
    upd_start_dp       = 1'b0;
    drw_start_dp       = 1'b1;
    upd_instruction_dp = 32'h0000_1234;
    drw_instruction_dp = 32'h0000_BEEF;
    finished_dp        = 1'b1;
    result_dp          = 16'h5A5A;
    pulse_tick();
    cyc = 1;
    #1;
    check_eq("mux_upd_start_ignores_drw", 32'(start_dp), 32'd0);
    check_eq("mux_upd_instr", instruction_dp, 32'h0000_1234);
    check_eq("mux_upd_finished", 32'(upd_finished_dp), 32'd1);
    check_eq("mux_upd_result", 32'(upd_result_dp), 32'h5A5A);
    check_eq("mux_drw_finished_masked", 32'(drw_finished_dp), 32'd0);
    check_eq("mux_drw_result_masked", 32'(drw_result_dp), 32'd0);
    upd_start_dp = 1'b1;
    #1;
    check_eq("mux_upd_start_follows", 32'(start_dp), 32'd1);
    while (drw_start !== 1'b1 && cyc < 400) step();
    check_eq("f2_drw_go_cycle", 32'(cyc), 32'd8);
    upd_start_dp = 1'b1;
    drw_start_dp = 1'b0;
    #1;
    check_eq("mux_drw_start_ignores_upd", 32'(start_dp), 32'd0);
    check_eq("mux_drw_instr", instruction_dp, 32'h0000_BEEF);
    check_eq("mux_drw_finished", 32'(drw_finished_dp), 32'd1);
    check_eq("mux_upd_finished_masked", 32'(upd_finished_dp), 32'd0);
    check_eq("mux_upd_result_masked", 32'(upd_result_dp), 32'd0);
    clear_dp();
    while (cyc < 10) step();
    pulse_tick();
    cyc++;
    check_eq("f2_overrun_set", 32'(overrun), 32'd1);
    while (frame_done !== 1'b1 && cyc < 400) step();
    check_eq("f2_pass_len", 32'(cyc), 32'(PassCycles));
    repeat (60) step();
    check_eq("f2_overrun_sticky", 32'(overrun), 32'd1);
    check_eq("f2_done_pulses", 32'(n_done - base_f), 32'd1);
    check_eq("f2_upd_pulses", 32'(n_upd_start - base_u), 32'd3);
    check_eq("f2_idle", 32'(busy), 32'd0);

    // Reset in DRW_WAIT of ant 1.
    apply_reset();
    check_eq("f3_overrun_cleared", 32'(overrun), 32'd0);
    pulse_tick();
    cyc = 1;
    while (!(drw_start === 1'b1 && ant_id === 8'd1) && cyc < 400) step();
    step();
    check_eq("f3_pre_reset_id", 32'(ant_id), 32'd1);
    drw_start_dp = 1'b1;
    #1;
    check_eq("f3_pre_reset_start_dp", 32'(start_dp), 32'd1);
    reset = 1'b1;
    step();
    check_eq("f3_rst_busy", 32'(busy), 32'd0);
    check_eq("f3_rst_ant_id", 32'(ant_id), 32'd0);
    check_eq("f3_rst_start_dp", 32'(start_dp), 32'd0);
    check_eq("f3_rst_drw_start", 32'(drw_start), 32'd0);
    reset = 1'b0;
    drw_start_dp = 1'b0;
    step();
    pulse_tick();
    cyc = 1;
    check_eq("f3_restart_id", 32'(ant_id), 32'd0);
    check_eq("f3_restart_upd_start", 32'(upd_start), 32'd1);
    while (frame_done !== 1'b1 && cyc < 400) step();
    check_eq("f3_pass_len", 32'(cyc), 32'(PassCycles));
    repeat (3) step();

`ifndef ANT_SCHED_WATCHDOG_EN
    // Finished level that never drops must not count as completion.
    upd_stuck = 1'b1;
    base_u = n_upd_start; base_d = n_drw_start; base_f = n_done;
    pulse_tick();
    cyc = 1;
    repeat (40) step();
    check_eq("stuck_no_drw_start", 32'(n_drw_start - base_d), 32'd0);
    check_eq("stuck_one_upd_start", 32'(n_upd_start - base_u), 32'd1);
    check_eq("stuck_busy", 32'(busy), 32'd1);
    check_eq("stuck_ant_id", 32'(ant_id), 32'd0);
    check_eq("stuck_no_done", 32'(n_done - base_f), 32'd0);
    upd_stuck = 1'b0;
    apply_reset();
`else
    // Update engine that never finishes: watchdog fires after 16 wait cycles.
    upd_hang = 1'b1;
    pulse_tick();
    cyc = 1;
    while (cyc < 17) step();
    check_eq("wd_not_yet", 32'(timeout_err), 32'd0);
    check_eq("wd_no_drw_yet", 32'(drw_start), 32'd0);
    step();
    check_eq("wd_timeout_err", 32'(timeout_err), 32'd1);
    check_eq("wd_drw_start", 32'(drw_start), 32'd1);
    check_eq("wd_same_id", 32'(ant_id), 32'd0);
    upd_hang = 1'b0;
    apply_reset();
    check_eq("wd_rst_clears", 32'(timeout_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
